// File: rtl/clk_monitor.sv
// clk_monitor: checks that an asynchronous clock (mon_in) toggles with the expected period.
// Optional high-time check is compiled in when CLK_MON_DUTY_EN is defined.
// Ports:
//   clk          in  1      sampling clock, all logic on its rising edge
//   rst          in  1      asynchronous, active-high reset
//   enable       in  1      1 = monitor runs, 0 = back to IDLE with status cleared
//   mon_in       in  1      monitored clock, asynchronous to clk
//   period_out   out CNT_W  last measured rise-to-rise period in clk cycles (held)
//   period_valid out 1      one-cycle pulse when period_out updates
//   err_period   out 1      pulse with period_valid when the period is out of tolerance
//   err_stuck    out 1      level, no rise for TIMEOUT cycles; cleared by the next rise
//   locked       out 1      level, LOCK_CNT consecutive good periods seen
//   err_duty     out 1      pulse with period_valid when the high time is out of tolerance
module clk_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 10,
    parameter int EXP_HIGH   = 5,
    parameter int TOL        = 1,
    parameter int TIMEOUT    = 64,
    parameter int LOCK_CNT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mon_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             err_period,
    output logic             err_stuck,
    output logic             locked,
    output logic             err_duty
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_EDGE = 2'd1;
    localparam logic [1:0] MEASURE   = 2'd2;
    localparam logic [1:0] LOCKED    = 2'd3;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] T_CNT = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_CNT);
    // Tolerance window one bit wider than the counter so the bounds never wrap.
    localparam logic [CNT_W:0] P_LO = (CNT_W+1)'((EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0);
    localparam logic [CNT_W:0] P_HI = (CNT_W+1)'(EXP_PERIOD + TOL);
    logic [1:0] state;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [GOOD_W-1:0] good_cnt, good_nxt;
    logic s1, s2, s3;
    logic rise, timeout, per_ok, duty_ok;
    // Two synchronizer flops plus one delay flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {s3, s2, s1} <= '0;
        else {s3, s2, s1} <= {s2, s1, mon_in};
    end
    assign rise     = s2 & ~s3;
    assign timeout  = cnt == T_CNT;
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign good_nxt = (good_cnt == LOCK_V) ? good_cnt : good_cnt + 1'b1;
    assign per_ok   = ({1'b0, cnt} >= P_LO) && ({1'b0, cnt} <= P_HI);
`ifdef CLK_MON_DUTY_EN
    localparam logic [CNT_W:0] H_LO = (CNT_W+1)'((EXP_HIGH > TOL) ? EXP_HIGH - TOL : 0);
    localparam logic [CNT_W:0] H_HI = (CNT_W+1)'(EXP_HIGH + TOL);
    logic [CNT_W-1:0] hcnt, high_lat;
    logic fall;
    assign fall    = s3 & ~s2;
    assign duty_ok = ({1'b0, high_lat} >= H_LO) && ({1'b0, high_lat} <= H_HI);
    // hcnt restarts at 1 on each rise so the latched value equals fall-minus-rise in clk cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt     <= '0;
            high_lat <= '0;
            err_duty <= 1'b0;
        end else begin
            err_duty <= 1'b0;
            if (!enable || state == IDLE) begin
                hcnt     <= '0;
                high_lat <= '0;
            end else begin
                hcnt <= rise ? CNT_W'(1) : s2 ? ((hcnt == CNT_MAX) ? hcnt : hcnt + 1'b1) : hcnt;
                if (fall) high_lat <= hcnt;
                if (rise && (state == MEASURE || state == LOCKED)) err_duty <= !duty_ok;
            end
        end
    end
`else
    assign duty_ok  = 1'b1;
    assign err_duty = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            err_period   <= 1'b0;
            err_stuck    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            err_period   <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                cnt       <= '0;
                good_cnt  <= '0;
                locked    <= 1'b0;
                err_stuck <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_EDGE;
                        cnt   <= '0;
                    end
                    WAIT_EDGE: begin
                        // The first edge only starts the count; it has no period to report.
                        if (rise) begin
                            state     <= MEASURE;
                            cnt       <= CNT_W'(1);
                            err_stuck <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                            if (timeout) begin
                                err_stuck <= 1'b1;
                                locked    <= 1'b0;
                                good_cnt  <= '0;
                            end
                        end
                    end
                    default: begin
                        // A rise takes priority over a coincident timeout.
                        if (rise) begin
                            cnt          <= CNT_W'(1);
                            period_out   <= cnt;
                            period_valid <= 1'b1;
                            err_period   <= !per_ok;
                            err_stuck    <= 1'b0;
                            if (per_ok && duty_ok) begin
                                good_cnt <= good_nxt;
                                if (good_nxt == LOCK_V) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                good_cnt <= '0;
                                locked   <= 1'b0;
                                state    <= MEASURE;
                            end
                        end else if (timeout) begin
                            cnt       <= cnt_inc;
                            err_stuck <= 1'b1;
                            locked    <= 1'b0;
                            good_cnt  <= '0;
                            state     <= WAIT_EDGE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: directed and random waveforms on mon_in checked against an edge-timing reference model.
module tb_clk_monitor;
    localparam int CNT_W      = 16;
    localparam int EXP_PERIOD = 10;
    localparam int EXP_HIGH   = 5;
    localparam int TOL        = 1;
    localparam int TIMEOUT    = 64;
    localparam int LOCK_CNT   = 4;
    localparam int MAXC       = (1 << CNT_W) - 1;
    logic clk = 1'b0;
    logic rst, enable, mon_in;
    logic [CNT_W-1:0] period_out;
    logic period_valid, err_period, err_stuck, locked, err_duty;
    int n_cmp = 0;
    int n_bad = 0;
    int md, a, good, hi, lastrise, n, mpout;
    bit mlock, mstuck, mpv, mep, med;
    bit dh [4];
    int c_pv, c_ep, c_ed;

    clk_monitor #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .EXP_HIGH(EXP_HIGH),
        .TOL(TOL), .TIMEOUT(TIMEOUT), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mon_in(mon_in),
        .period_out(period_out), .period_valid(period_valid), .err_period(err_period),
        .err_stuck(err_stuck), .locked(locked), .err_duty(err_duty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        md = 0; a = 0; good = 0; hi = 0; lastrise = 0; mpout = 0;
        mlock = 0; mstuck = 0; mpv = 0; mep = 0; med = 0;
        dh = '{default: 1'b0};
    endtask

    // Reference: a mon_in level present at edge k is acted on two edges later (2-flop sync),
    // periods are edge distances between recognised rises, timeout is TIMEOUT edges of count.
    task automatic model_edge();
        int c;
        bit r, f;
        n++;
        dh[3] = dh[2]; dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = mon_in;
        r = dh[2] && !dh[3];
        f = !dh[2] && dh[3];
        mpv = 0; mep = 0; med = 0;
        c = n - a;
        if (c > MAXC) c = MAXC;
        if (!enable) begin
            md = 0; good = 0; mlock = 0; mstuck = 0;
        end else if (md == 0) begin
            md = 1; a = n + 1;
        end else begin
            if (f) hi = n - lastrise;
            if (r) begin
                if (md == 2) begin
                    mpv = 1;
                    mpout = c;
                    mep = !(c >= EXP_PERIOD - TOL && c <= EXP_PERIOD + TOL);
`ifdef CLK_MON_DUTY_EN
                    med = !(hi >= EXP_HIGH - TOL && hi <= EXP_HIGH + TOL);
`endif
                    if (!mep && !med) begin
                        if (good < LOCK_CNT) good++;
                        if (good == LOCK_CNT) mlock = 1;
                    end else begin
                        good = 0; mlock = 0;
                    end
                end
                md = 2; a = n; mstuck = 0; lastrise = n;
            end else if (c == TIMEOUT) begin
                mstuck = 1; mlock = 0; good = 0; md = 1;
            end
        end
    endtask

    task automatic tick(input logic m, input string tag);
        mon_in = m;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, ".period_valid"}, period_valid, mpv);
        chk({tag, ".period_out"}, period_out, mpout);
        chk({tag, ".err_period"}, err_period, mep);
        chk({tag, ".err_stuck"}, err_stuck, mstuck);
        chk({tag, ".locked"}, locked, mlock);
        chk({tag, ".err_duty"}, err_duty, med);
        if (period_valid) c_pv++;
        if (err_period) c_ep++;
        if (err_duty) c_ed++;
    endtask

    task automatic wave(input int hh, input int ll, input string tag);
        repeat (hh) tick(1'b1, tag);
        repeat (ll) tick(1'b0, tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".period_valid"}, period_valid, 0);
        chk({tag, ".period_out"}, period_out, 0);
        chk({tag, ".err_period"}, err_period, 0);
        chk({tag, ".err_stuck"}, err_stuck, 0);
        chk({tag, ".locked"}, locked, 0);
        chk({tag, ".err_duty"}, err_duty, 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mon_in = 1'b0; n = 0;
        c_pv = 0; c_ep = 0; c_ed = 0;
        mreset();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (3) tick(1'b0, "idle");
        // nominal clock locks on the 5th rise
        enable = 1'b1; c_pv = 0;
        repeat (3) tick(1'b0, "nominal");
        repeat (8) wave(5, 5, "nominal");
        chk("nominal.locked_level", locked, 1);
        chk("nominal.period_value", period_out, 10);
        chk("nominal.valid_count", c_pv, 7);
        // one long period breaks lock, four good ones restore it
        c_ep = 0;
        wave(5, 8, "long");
        repeat (6) wave(5, 5, "long");
        chk("long.err_count", c_ep, 1);
        chk("long.relock", locked, 1);
        // stuck low, then resume
        repeat (80) tick(1'b0, "stuck");
        chk("stuck.flag", err_stuck, 1);
        chk("stuck.unlock", locked, 0);
        repeat (6) wave(5, 5, "resume");
        chk("resume.flag_clear", err_stuck, 0);
        chk("resume.relock", locked, 1);
        // tolerance boundaries 9 and 11 pass, 8 fails
        c_ep = 0;
        wave(5, 4, "tol"); wave(6, 5, "tol"); wave(4, 4, "tol");
        wave(5, 5, "tol"); wave(5, 5, "tol");
        chk("tol.err_count", c_ep, 1);
        // period of exactly TIMEOUT: rise wins; one cycle longer: stuck first
        wave(32, 32, "edge64"); wave(5, 5, "edge64");
        wave(32, 33, "edge65"); repeat (6) wave(5, 5, "edge65");
        chk("edge65.relock", locked, 1);
        // enable low mid-lock
        enable = 1'b0;
        tick(1'b1, "disable"); tick(1'b1, "disable");
        chk("disable.locked", locked, 0);
        chk("disable.no_valid", period_valid, 0);
        enable = 1'b1;
        repeat (6) wave(5, 5, "reenable");
        chk("reenable.locked", locked, 1);
        // asynchronous reset mid-count
        tick(1'b1, "prerst"); tick(1'b1, "prerst");
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        mreset();
        @(negedge clk);
        rst = 1'b0;
        repeat (7) wave(5, 5, "postrst");
        chk("postrst.locked", locked, 1);
        // high time 8 of 10
        c_ed = 0;
        repeat (8) wave(8, 2, "duty");
`ifdef CLK_MON_DUTY_EN
        chk("duty.locked", locked, 0);
        chk("duty.err_count", c_ed, 7);
`else
        chk("duty.locked", locked, 1);
        chk("duty.err_count", c_ed, 0);
`endif
        repeat (6) wave(5, 5, "duty_ok");
        chk("duty_ok.locked", locked, 1);
        // random waveforms, occasional long gaps and enable drops
        repeat (80) begin
            int hh, ll;
            hh = $urandom_range(2, 8);
            ll = ($urandom_range(0, 9) == 0) ? $urandom_range(55, 75) : $urandom_range(2, 8);
            enable = ($urandom_range(0, 19) != 0);
            wave(hh, ll, "rnd");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
